// File: rtl/or_tester_pkg.sv
// Shared types and helpers for the quad OR gate self-test sequencer.
package or_tester_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;

    localparam int NUM_GATES   = 4;
    localparam int NUM_VECTORS = 16;
    localparam logic [3:0] LAST_VEC = 4'(NUM_VECTORS - 1);

    // B is A rotated left by one so every gate sees all four (A,B) pairs over 16 vectors.
    function automatic logic [NUM_GATES-1:0] vec_b(input logic [NUM_GATES-1:0] k);
        return {k[NUM_GATES-2:0], k[NUM_GATES-1]};
    endfunction

endpackage

// File: rtl/or_tester_vecgen.sv
// Maps the vector index to the A/B stimulus and the expected OR result.
module or_tester_vecgen
    import or_tester_pkg::*;
(
    input  logic [NUM_GATES-1:0] k,
    output logic [NUM_GATES-1:0] a,
    output logic [NUM_GATES-1:0] b,
    output logic [NUM_GATES-1:0] e
);

    assign a = k;
    assign b = vec_b(k);
    assign e = a | b;

endmodule

// File: rtl/or_gate_tester.sv
// Self-test sequencer for a quad 2-input OR gate block: walks 16 vectors,
// waits a settle window per vector and records per-gate verdicts.
//
// state  | meaning
// IDLE   | gate inputs at 0, waiting for START
// DRIVE  | register the current vector onto A_OUT/B_OUT, load settle counter
// SETTLE | count down the settle window
// CHECK  | compare Y_IN against expected, advance or finish
// FIN    | one-cycle DONE pulse, results valid
module or_gate_tester
    import or_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic [3:0] A_OUT,
    output logic [3:0] B_OUT,
    input  logic [3:0] Y_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] PASS,
    output logic       RESULT_VALID,
    output logic       FAIL_VALID,
    output logic [3:0] FAIL_VEC
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] vec_k;
    logic [7:0] settle_cnt;
    logic [3:0] vec_a;
    logic [3:0] vec_bp;
    logic [3:0] vec_e;
    logic [3:0] mismatch;

    or_tester_vecgen u_vecgen (
        .k (vec_k),
        .a (vec_a),
        .b (vec_bp),
        .e (vec_e)
    );

    assign mismatch = Y_IN ^ vec_e;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            vec_k        <= '0;
            settle_cnt   <= '0;
            A_OUT        <= '0;
            B_OUT        <= '0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            PASS         <= '0;
            RESULT_VALID <= 1'b0;
            FAIL_VALID   <= 1'b0;
            FAIL_VEC     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    A_OUT <= '0;
                    B_OUT <= '0;
                    if (START) begin
                        PASS         <= 4'hF;
                        FAIL_VALID   <= 1'b0;
                        FAIL_VEC     <= '0;
                        RESULT_VALID <= 1'b0;
                        vec_k        <= '0;
                        BUSY         <= 1'b1;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    A_OUT      <= vec_a;
                    B_OUT      <= vec_bp;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    PASS <= PASS & ~mismatch;
                    // Only the first failing vector of a run is latched.
                    if ((|mismatch) && !FAIL_VALID) begin
                        FAIL_VALID <= 1'b1;
                        FAIL_VEC   <= vec_k;
                    end
                    if (vec_k == LAST_VEC) begin
                        BUSY         <= 1'b0;
                        DONE         <= 1'b1;
                        RESULT_VALID <= 1'b1;
                        A_OUT        <= '0;
                        B_OUT        <= '0;
                        state        <= FIN;
                    end else begin
                        vec_k <= vec_k + 4'd1;
                        state <= DRIVE;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    vec_k <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_gate_tester.sv
// Self-checking bench for or_gate_tester: fault-injecting gate model, table and random runs.
module tb_or_gate_tester;

    typedef logic [3:0][2:0] fault_t;   // per gate: 0 OR, 1 stuck0, 2 stuck1, 3 AND, 4 XOR

    typedef struct {
        string      name;
        fault_t     f;
        logic [3:0] pass;
        logic       fv;
        logic [3:0] fvec;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_lag;
    fault_t     fault_cur;
    logic [3:0] a_out, b_out, y_in, pass, fail_vec;
    logic       busy, done, result_valid, fail_valid;
    logic [3:0] l1_a, l1_b, l1_y, l1_pass, l1_fvec, l1_d1, l1_d2;
    logic       l1_busy, l1_done, l1_rv, l1_fv;
    logic [3:0] l3_a, l3_b, l3_y, l3_pass, l3_fvec, l3_d1, l3_d2;
    logic       l3_busy, l3_done, l3_rv, l3_fv;

    int tests = 0;
    int fails = 0;

    function automatic logic [3:0] faulty_y(input fault_t f, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] y;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            case (f[i])
                3'd1:    y[i] = 1'b0;
                3'd2:    y[i] = 1'b1;
                3'd3:    y[i] = a[i] & b[i];
                3'd4:    y[i] = a[i] ^ b[i];
                default: y[i] = a[i] | b[i];
            endcase
        end
        return y;
    endfunction

    always_comb y_in = faulty_y(fault_cur, a_out, b_out);

    // Gate block whose output lags its inputs by two clock cycles.
    always_ff @(posedge clk) begin
        l1_d1 <= l1_a | l1_b;
        l1_d2 <= l1_d1;
        l3_d1 <= l3_a | l3_b;
        l3_d2 <= l3_d1;
    end
    assign l1_y = l1_d2;
    assign l3_y = l3_d2;

    or_gate_tester #(.SETTLE_CYCLES(2)) dut (
        .CLK(clk), .RST(rst), .START(start), .A_OUT(a_out), .B_OUT(b_out), .Y_IN(y_in),
        .BUSY(busy), .DONE(done), .PASS(pass), .RESULT_VALID(result_valid),
        .FAIL_VALID(fail_valid), .FAIL_VEC(fail_vec)
    );

    or_gate_tester #(.SETTLE_CYCLES(1)) dut_s1 (
        .CLK(clk), .RST(rst), .START(start_lag), .A_OUT(l1_a), .B_OUT(l1_b), .Y_IN(l1_y),
        .BUSY(l1_busy), .DONE(l1_done), .PASS(l1_pass), .RESULT_VALID(l1_rv),
        .FAIL_VALID(l1_fv), .FAIL_VEC(l1_fvec)
    );

    or_gate_tester #(.SETTLE_CYCLES(3)) dut_s3 (
        .CLK(clk), .RST(rst), .START(start_lag), .A_OUT(l3_a), .B_OUT(l3_b), .Y_IN(l3_y),
        .BUSY(l3_busy), .DONE(l3_done), .PASS(l3_pass), .RESULT_VALID(l3_rv),
        .FAIL_VALID(l3_fv), .FAIL_VEC(l3_fvec)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Reference: walk the 16 vectors arithmetically. lag=1 models a gate whose
    // Y shows the previous vector's OR at check time (ideal gates otherwise).
    function automatic void ref_model(input fault_t f, input bit lag,
                                      output logic [3:0] p, output logic fv, output logic [3:0] fvec);
        int e_prev;
        e_prev = 0;
        p = 4'hF; fv = 1'b0; fvec = 4'h0;
        for (int k = 0; k < 16; k++) begin
            int a, b, e, y, mism;
            a = k;
            b = ((k * 2) % 16) + (k / 8);
            e = a | b;
            y = lag ? e_prev : int'(faulty_y(f, 4'(a), 4'(b)));
            mism = (y ^ e) & 15;
            p = p & ~4'(mism);
            if (mism != 0 && !fv) begin
                fv = 1'b1;
                fvec = 4'(k);
            end
            e_prev = e;
        end
    endfunction

    // One run of the main DUT; returns the cycle (1 = first DRIVE) of DONE.
    task automatic run_main(input bit jab, output int lat, output int vec_err);
        lat = -1;
        vec_err = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (done) begin
                lat = c;
                start = 1'b0;
                break;
            end
            if (c == 1 && !busy) vec_err++;
            if ((c - 1) % 4 == 2) begin
                int k;
                logic [3:0] eb;
                k = (c - 1) / 4;
                eb = 4'(((k * 2) % 16) + (k / 8));
                if (a_out !== 4'(k) || b_out !== eb || !busy) vec_err++;
            end
            if (jab) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string name, input fault_t f, input logic [3:0] ep,
                                 input logic efv, input logic [3:0] efvec, input bit jab);
        int lat, verr;
        fault_cur = f;
        run_main(jab, lat, verr);
        check({name, " latency"}, lat, 65);
        check({name, " vectors"}, verr, 0);
        check({name, " PASS"}, pass, ep);
        check({name, " FAIL_VALID"}, fail_valid, efv);
        check({name, " FAIL_VEC"}, fail_vec, efvec);
        check({name, " RESULT_VALID"}, result_valid, 1);
        check({name, " BUSY at DONE"}, busy, 0);
        @(negedge clk);
        check({name, " DONE one cycle"}, done, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];

    initial begin
        logic [3:0] ep, efvec;
        logic       efv;
        fault_t     f;
        int         ndone, l1_lat, l3_lat;
        int         done_cyc[3];
        logic [3:0] done_pass[3];

        f = '0;
        tbl[0] = '{"ideal", f, 4'hF, 1'b0, 4'd0};
        f = '0; f[2] = 3'd1;
        tbl[1] = '{"g2_stuck0", f, 4'b1011, 1'b1, 4'd2};
        f = '0; f[0] = 3'd3;
        tbl[2] = '{"g0_and", f, 4'b1110, 1'b1, 4'd1};
        f = '0; f[1] = 3'd2;
        tbl[3] = '{"g1_stuck1", f, 4'b1101, 1'b1, 4'd0};
        f = '0; f[3] = 3'd4;
        tbl[4] = '{"g3_xor", f, 4'b0111, 1'b1, 4'd12};
        f = '0; f[0] = 3'd1; f[1] = 3'd1; f[2] = 3'd1; f[3] = 3'd1;
        tbl[5] = '{"all_stuck0", f, 4'b0000, 1'b1, 4'd1};

        rst = 1'b1; start = 1'b0; start_lag = 1'b0; fault_cur = '0;
        repeat (3) @(negedge clk);
        check("reset A_OUT", a_out, 0);
        check("reset B_OUT", b_out, 0);
        check("reset BUSY", busy, 0);
        check("reset DONE", done, 0);
        check("reset PASS", pass, 0);
        check("reset RESULT_VALID", result_valid, 0);
        check("reset FAIL_VALID", fail_valid, 0);
        check("reset FAIL_VEC", fail_vec, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_and_check(tbl[i].name, tbl[i].f, tbl[i].pass, tbl[i].fv, tbl[i].fvec, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int g = 0; g < 4; g++) f[g] = 3'($urandom_range(0, 4));
            ref_model(f, 1'b0, ep, efv, efvec);
            run_and_check($sformatf("rand%0d", t), f, ep, efv, efvec, 1'b1);
        end

        // Reset in the middle of a run.
        fault_cur = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst A_OUT", a_out, 0);
        check("midrst B_OUT", b_out, 0);
        check("midrst BUSY", busy, 0);
        check("midrst DONE", done, 0);
        check("midrst PASS", pass, 0);
        check("midrst RESULT_VALID", result_valid, 0);
        check("midrst FAIL_VALID", fail_valid, 0);
        check("midrst FAIL_VEC", fail_vec, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no DONE", ndone, 0);
        run_and_check("after_rst", '0, 4'hF, 1'b0, 4'd0, 1'b0);

        // START held high: back-to-back runs, PASS reloaded each start.
        f = '0; f[0] = 3'd3;
        fault_cur = f;
        ndone = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) begin
                    done_cyc[ndone] = c;
                    done_pass[ndone] = pass;
                end
                ndone++;
                fault_cur = '0;
            end
            if (c == 66) check("held IDLE RESULT_VALID", result_valid, 1);
            if (c == 67) begin
                check("held restart RESULT_VALID", result_valid, 0);
                check("held restart PASS", pass, 4'hF);
                check("held restart BUSY", busy, 1);
            end
        end
        start = 1'b0;
        check("held DONE count", ndone, 3);
        if (ndone >= 3) begin
            check("held DONE1 cycle", done_cyc[0], 65);
            check("held DONE2 cycle", done_cyc[1], 131);
            check("held DONE3 cycle", done_cyc[2], 197);
            check("held run1 PASS", done_pass[0], 4'b1110);
            check("held run2 PASS", done_pass[1], 4'hF);
            check("held run3 PASS", done_pass[2], 4'hF);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Lagging gate: settle of 1 misses the lag, settle of 3 covers it.
        l1_lat = -1; l3_lat = -1;
        @(negedge clk) start_lag = 1'b1;
        @(negedge clk) start_lag = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (l1_done && l1_lat < 0) begin
                l1_lat = c;
                ref_model('0, 1'b1, ep, efv, efvec);
                check("lag s1 PASS", l1_pass, ep);
                check("lag s1 FAIL_VALID", l1_fv, efv);
                check("lag s1 FAIL_VEC", l1_fvec, efvec);
            end
            if (l3_done && l3_lat < 0) begin
                l3_lat = c;
                check("lag s3 PASS", l3_pass, 4'hF);
                check("lag s3 FAIL_VALID", l3_fv, 0);
                check("lag s3 RESULT_VALID", l3_rv, 1);
            end
            if (l1_lat > 0 && l3_lat > 0) break;
            @(negedge clk);
        end
        check("lag s1 latency", l1_lat, 49);
        check("lag s3 latency", l3_lat, 81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
